// File: rtl/top_clock.sv
// top_clock
//
// Top level of the temperature-sensor board. It contains:
//   * an I2C master that sends {addr, rw} and then either reads one byte
//     (rw=1, master NACKs it) or writes the pointer byte 0x00 (rw=0);
//   * a holding register for the last successfully read byte;
//   * a 4-digit multiplexed 7-segment display showing that byte in decimal.
//
// Request semantics: ena is a level request with no ready/ack. It is looked at
// only while the engine is idle (READY). Once a transaction starts it always
// runs to its STOP, and a still-high ena starts the next one immediately.
//
// Ports:
//   clk      system clock, all logic on the rising edge
//   reset_n  asynchronous active-low reset
//   ena      transaction request (level)
//   ena2     display enable
//   addr     7-bit slave address, latched at transaction start
//   rw       1 = read one byte, 0 = write pointer 0x00, latched at start
//   data_rd  last byte read with a fully acknowledged address phase
//   seg      active-low segments, bit 7 = dp (always off), [6:0] = g..a
//   an       active-low digit enables, an[3] leftmost
//   sda/scl  open-drain I2C lines, driven 0 or Z only
module top_clock #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int I2C_HZ    = 100_000,
    parameter int SCAN_BITS = 18
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ena,
    input  logic       ena2,
    input  logic [6:0] addr,
    input  logic       rw,
    output logic [7:0] data_rd,
    output logic [7:0] seg,
    output logic [3:0] an,
    inout  wire        sda,
    inout  wire        scl
);

    // Clocks per quarter of an SCL period.
    localparam int QTR   = CLK_HZ / (I2C_HZ * 4);
    localparam int CNT_W = (QTR > 1) ? $clog2(QTR) : 1;

    localparam logic [3:0] S_READY    = 4'd0;
    localparam logic [3:0] S_START    = 4'd1;
    localparam logic [3:0] S_COMMAND  = 4'd2;
    localparam logic [3:0] S_SLV_ACK1 = 4'd3;
    localparam logic [3:0] S_WR       = 4'd4;
    localparam logic [3:0] S_RD       = 4'd5;
    localparam logic [3:0] S_SLV_ACK2 = 4'd6;
    localparam logic [3:0] S_MSTR_ACK = 4'd7;
    localparam logic [3:0] S_STOP     = 4'd8;

    // I2C engine state
    logic [3:0]       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [1:0]       phase_q,   phase_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       tx_q,      tx_d;
    logic             rw_q,      rw_d;
    logic             ack_q,     ack_d;
    logic [7:0]       rx_q,      rx_d;
    logic [7:0]       data_rd_q, data_rd_d;
    logic             sda_low_q, sda_low_d;

    // Display state
    logic [SCAN_BITS-1:0] scan_q, scan_d;
    logic [3:0]           an_q,   an_d;
    logic [7:0]           seg_q,  seg_d;

    logic        qtr_tick;
    logic        scl_low;
    logic        sda_in;
    logic [1:0]  digit_sel;
    logic [11:0] bcd;

    // Phases 0,1 = SCL low, 2,3 = SCL high. qtr_tick ends the current phase,
    // so "tick in phase 0" is the middle of SCL-low (SDA update point) and
    // "tick in phase 2" is the middle of SCL-high (SDA sample point).
    assign qtr_tick = (cnt_q == CNT_W'(QTR - 1));

    // SCL is held released through START so the SDA fall happens with SCL high.
    assign scl_low = (state_q != S_READY) && (state_q != S_START) && !phase_q[1];

    assign scl    = scl_low   ? 1'b0 : 1'bz;
    assign sda    = sda_low_q ? 1'b0 : 1'bz;
    assign sda_in = sda;

    function automatic logic [11:0] to_bcd(input logic [7:0] bin);
        logic [19:0] sh;
        sh = {12'd0, bin};
        for (int i = 0; i < 8; i++) begin
            if (sh[11:8]  >= 4'd5) sh[11:8]  = sh[11:8]  + 4'd3;
            if (sh[15:12] >= 4'd5) sh[15:12] = sh[15:12] + 4'd3;
            if (sh[19:16] >= 4'd5) sh[19:16] = sh[19:16] + 4'd3;
            sh = sh << 1;
        end
        return sh[19:8];
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] c;
        case (d)
            4'd0:    c = 7'h40;
            4'd1:    c = 7'h79;
            4'd2:    c = 7'h24;
            4'd3:    c = 7'h30;
            4'd4:    c = 7'h19;
            4'd5:    c = 7'h12;
            4'd6:    c = 7'h02;
            4'd7:    c = 7'h78;
            4'd8:    c = 7'h00;
            4'd9:    c = 7'h10;
            default: c = 7'h7F;
        endcase
        return c;
    endfunction

    // I2C engine next state
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        rw_d      = rw_q;
        ack_d     = ack_q;
        rx_d      = rx_q;
        data_rd_d = data_rd_q;
        sda_low_d = sda_low_q;

        if (state_q == S_READY) begin
            cnt_d     = '0;
            phase_d   = 2'd0;
            bit_cnt_d = 3'd0;
            sda_low_d = 1'b0;
            if (ena) begin
                tx_d    = {addr, rw};
                rw_d    = rw;
                state_d = S_START;
            end
        end else begin
            if (qtr_tick) begin
                cnt_d   = '0;
                phase_d = phase_q + 2'd1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end

            // Middle of SCL low: put the next bit on SDA.
            if (qtr_tick && phase_q == 2'd0) begin
                case (state_q)
                    S_START:   sda_low_d = 1'b1;
                    S_COMMAND: sda_low_d = ~tx_q[7];
                    S_WR:      sda_low_d = 1'b1;
                    S_STOP:    sda_low_d = 1'b1;
                    default:   sda_low_d = 1'b0;
                endcase
            end

            // Middle of SCL high: sample, or release SDA for the STOP edge.
            if (qtr_tick && phase_q == 2'd2) begin
                case (state_q)
                    S_SLV_ACK1: ack_d     = sda_in;
                    S_RD:       rx_d      = {rx_q[6:0], sda_in};
                    S_STOP:     sda_low_d = 1'b0;
                    default:    ;
                endcase
            end

            // End of the bit: advance the FSM.
            if (qtr_tick && phase_q == 2'd3) begin
                case (state_q)
                    S_START: begin
                        state_d   = S_COMMAND;
                        bit_cnt_d = 3'd0;
                    end
                    S_COMMAND: begin
                        tx_d      = {tx_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_d = S_SLV_ACK1;
                    end
                    S_SLV_ACK1: begin
                        if (!ack_q) state_d = rw_q ? S_RD : S_WR;
                        else        state_d = S_STOP;
                    end
                    S_WR: begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_d = S_SLV_ACK2;
                    end
                    S_SLV_ACK2: state_d = S_STOP;
                    S_RD: begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_d = S_MSTR_ACK;
                    end
                    S_MSTR_ACK: begin
                        // Only reachable after an ACKed address with rw=1.
                        data_rd_d = rx_q;
                        state_d   = S_STOP;
                    end
                    S_STOP:  state_d = S_READY;
                    default: state_d = S_READY;
                endcase
            end
        end
    end

    // Display next state: digit select follows the top two scan bits,
    // an[0] (ones) first and an[3] (blank) last.
    assign bcd       = to_bcd(data_rd_q);
    assign digit_sel = scan_q[SCAN_BITS-1 -: 2];

    always_comb begin
        scan_d = scan_q + SCAN_BITS'(1);
        an_d   = 4'b1111;
        seg_d  = 8'hFF;
        if (ena2) begin
            case (digit_sel)
                2'd0: begin an_d = 4'b1110; seg_d = {1'b1, seg_code(bcd[3:0])};  end
                2'd1: begin an_d = 4'b1101; seg_d = {1'b1, seg_code(bcd[7:4])};  end
                2'd2: begin an_d = 4'b1011; seg_d = {1'b1, seg_code(bcd[11:8])}; end
                default: begin an_d = 4'b0111; seg_d = 8'hFF; end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_READY;
            cnt_q     <= '0;
            phase_q   <= 2'd0;
            bit_cnt_q <= 3'd0;
            tx_q      <= 8'h00;
            rw_q      <= 1'b0;
            ack_q     <= 1'b1;
            rx_q      <= 8'h00;
            data_rd_q <= 8'h00;
            sda_low_q <= 1'b0;
            scan_q    <= '0;
            an_q      <= 4'b1111;
            seg_q     <= 8'hFF;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            rw_q      <= rw_d;
            ack_q     <= ack_d;
            rx_q      <= rx_d;
            data_rd_q <= data_rd_d;
            sda_low_q <= sda_low_d;
            scan_q    <= scan_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign data_rd = data_rd_q;
    assign seg     = seg_q;
    assign an      = an_q;

endmodule

// File: tb/tb_top_clock.sv
`timescale 1ns/1ps
module tb_top_clock;

    localparam int CLK_HZ    = 4_000_000;
    localparam int I2C_HZ    = 100_000;
    localparam int SCAN_BITS = 6;
    localparam int QTR       = 10;
    localparam int DWELL     = 16;
    localparam logic [6:0] SLV_ADDR = 7'h48;

    localparam int M_IDLE  = 0;
    localparam int M_ADDR  = 1;
    localparam int M_AACK  = 2;
    localparam int M_RDATA = 3;
    localparam int M_MACK  = 4;
    localparam int M_WDATA = 5;
    localparam int M_WACK  = 6;

    // ---------------- clock / reset / DUT ----------------
    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       ena     = 1'b0;
    logic       ena2    = 1'b0;
    logic [6:0] addr_i  = 7'd0;
    logic       rw_i    = 1'b0;
    logic [7:0] data_rd;
    logic [7:0] seg;
    logic [3:0] an;
    wire        sda;
    wire        scl;

    always #5 clk = ~clk;

    pullup (sda);
    pullup (scl);

    top_clock #(
        .CLK_HZ   (CLK_HZ),
        .I2C_HZ   (I2C_HZ),
        .SCAN_BITS(SCAN_BITS)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .ena    (ena),
        .ena2   (ena2),
        .addr   (addr_i),
        .rw     (rw_i),
        .data_rd(data_rd),
        .seg    (seg),
        .an     (an),
        .sda    (sda),
        .scl    (scl)
    );

    // ---------------- slave model + bus monitor ----------------
    logic       slave_present = 1'b0;
    logic [7:0] rd_val        = 8'h00;
    logic       sl_drive      = 1'b0;
    assign sda = (sl_drive && reset_n) ? 1'b0 : 1'bz;

    int         mode       = M_IDLE;
    int         bit_n      = 0;
    int         start_cnt  = 0;
    int         stop_cnt   = 0;
    int         rise_cnt   = 0;
    int         fall_total = 0;
    logic [7:0] sh         = 8'h00;
    logic [7:0] tx_sh      = 8'h00;
    logic       mack_v     = 1'b0;
    logic       prev_scl   = 1'b1;
    logic       prev_sda   = 1'b1;
    logic       scl_v;
    logic       sda_v;
    logic [7:0] byte_q[$];

    initial begin
        forever begin
            @(negedge clk);
            scl_v = (scl !== 1'b0);
            sda_v = (sda !== 1'b0);
            if (!reset_n) begin
                mode     = M_IDLE;
                sl_drive = 1'b0;
                bit_n    = 0;
            end else if (prev_scl && scl_v && prev_sda && !sda_v) begin
                start_cnt++;
                mode     = M_ADDR;
                bit_n    = 0;
                sh       = 8'h00;
                rise_cnt = 0;
                mack_v   = 1'b0;
                sl_drive = 1'b0;
            end else if (prev_scl && scl_v && !prev_sda && sda_v) begin
                stop_cnt++;
                mode     = M_IDLE;
                sl_drive = 1'b0;
            end else if (!prev_scl && scl_v) begin
                rise_cnt++;
                case (mode)
                    M_ADDR, M_WDATA: begin sh = {sh[6:0], sda_v}; bit_n++; end
                    M_RDATA:         bit_n++;
                    M_MACK:          mack_v = sda_v;
                    default:         ;
                endcase
            end else if (prev_scl && !scl_v) begin
                fall_total++;
                case (mode)
                    M_ADDR: if (bit_n == 8) begin
                        byte_q.push_back(sh);
                        if (slave_present && sh[7:1] == SLV_ADDR) begin
                            sl_drive = 1'b1;
                            mode     = M_AACK;
                        end else begin
                            mode = M_IDLE;
                        end
                    end
                    M_AACK: begin
                        bit_n = 0;
                        if (sh[0]) begin
                            tx_sh    = rd_val;
                            sl_drive = ~tx_sh[7];
                            mode     = M_RDATA;
                        end else begin
                            sl_drive = 1'b0;
                            sh       = 8'h00;
                            mode     = M_WDATA;
                        end
                    end
                    M_RDATA: begin
                        if (bit_n == 8) begin
                            sl_drive = 1'b0;
                            mode     = M_MACK;
                        end else begin
                            tx_sh    = {tx_sh[6:0], 1'b0};
                            sl_drive = ~tx_sh[7];
                        end
                    end
                    M_WDATA: if (bit_n == 8) begin
                        byte_q.push_back(sh);
                        sl_drive = 1'b1;
                        mode     = M_WACK;
                    end
                    M_WACK:  begin sl_drive = 1'b0; mode = M_IDLE; end
                    M_MACK:  mode = M_IDLE;
                    default: ;
                endcase
            end
            prev_scl = scl_v;
            prev_sda = sda_v;
        end
    end

    // ---------------- scoreboard counters ----------------
    int errors = 0;
    int checks = 0;

    // ---------------- driver tasks ----------------
    task automatic do_txn(input logic [6:0] a, input logic r,
                          output bit ok_start, output bit ok_stop, output int lat);
        int s0;
        int p0;
        s0 = start_cnt;
        p0 = stop_cnt;
        addr_i = a;
        rw_i   = r;
        ena    = 1'b1;
        lat      = 0;
        ok_start = 1'b0;
        for (int i = 0; i < QTR * 4; i++) begin
            @(negedge clk);
            lat++;
            if (start_cnt > s0) begin ok_start = 1'b1; break; end
        end
        ena     = 1'b0;
        ok_stop = 1'b0;
        for (int i = 0; i < QTR * 4 * 30; i++) begin
            @(negedge clk);
            if (stop_cnt > p0) begin ok_stop = 1'b1; break; end
        end
        // let the engine finish STOP and settle in READY
        repeat (QTR * 2) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        ena     = 1'b0;
        ena2    = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (scl !== 1'b1) begin errors++; $display("FAIL reset_scl: got %b want 1", scl); end
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b want 1", sda); end
        checks++; if (data_rd !== 8'h00) begin errors++; $display("FAIL reset_data_rd: got %h want 00", data_rd); end
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL reset_an: got %b want 1111", an); end
        checks++; if (seg !== 8'hFF) begin errors++; $display("FAIL reset_seg: got %h want ff", seg); end
        reset_n = 1'b1;
        repeat (QTR * 16) @(negedge clk);
        checks++; if (start_cnt !== 0) begin errors++; $display("FAIL idle_start: got %0d want 0", start_cnt); end
        checks++; if (fall_total !== 0) begin errors++; $display("FAIL idle_scl_falls: got %0d want 0", fall_total); end
        checks++; if (sda !== 1'b1 || scl !== 1'b1) begin errors++; $display("FAIL idle_lines: got scl=%b sda=%b want 1 1", scl, sda); end
    endtask

    task automatic test_read();
        bit ok_s, ok_p;
        int lat, n0;
        slave_present = 1'b1;
        rd_val        = 8'h19;
        n0            = byte_q.size();
        do_txn(SLV_ADDR, 1'b1, ok_s, ok_p, lat);
        checks++; if (!ok_s) begin errors++; $display("FAIL read_start: got none want START"); end
        checks++; if (lat > QTR + 3) begin errors++; $display("FAIL read_start_latency: got %0d want <= %0d", lat, QTR + 3); end
        checks++; if (!ok_p) begin errors++; $display("FAIL read_stop: got none want STOP"); end
        checks++; if (byte_q.size() !== n0 + 1) begin errors++; $display("FAIL read_nbytes: got %0d want %0d", byte_q.size() - n0, 1); end
        checks++; if (byte_q[n0] !== 8'h91) begin errors++; $display("FAIL read_addr_byte: got %h want 91", byte_q[n0]); end
        checks++; if (rise_cnt !== 19) begin errors++; $display("FAIL read_scl_pulses: got %0d want 19", rise_cnt); end
        checks++; if (mack_v !== 1'b1) begin errors++; $display("FAIL read_master_nack: got %b want 1", mack_v); end
        checks++; if (data_rd !== 8'h19) begin errors++; $display("FAIL read_data_rd: got %h want 19", data_rd); end
    endtask

    task automatic test_display();
        logic [3:0] an_exp [4];
        logic [7:0] seg_exp [4];
        logic [3:0] prev_an;
        bit found;
        int dwell;
        an_exp[0] = 4'b1110; seg_exp[0] = 8'h92;
        an_exp[1] = 4'b1101; seg_exp[1] = 8'hA4;
        an_exp[2] = 4'b1011; seg_exp[2] = 8'hC0;
        an_exp[3] = 4'b0111; seg_exp[3] = 8'hFF;
        ena2  = 1'b1;
        found = 1'b0;
        for (int i = 0; i < DWELL * 4 + 4; i++) begin
            @(negedge clk);
            if (an === 4'b1110) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin errors++; $display("FAIL disp_first_digit: got an=%b want 1110", an); end
        checks++; if (seg !== seg_exp[0]) begin errors++; $display("FAIL disp_seg0: got %h want %h", seg, seg_exp[0]); end
        for (int k = 1; k < 4; k++) begin
            prev_an = an;
            dwell   = 0;
            for (int i = 0; i < DWELL + 4; i++) begin
                @(negedge clk);
                dwell++;
                if (an !== prev_an) break;
            end
            checks++; if (an !== an_exp[k]) begin errors++; $display("FAIL disp_an%0d: got %b want %b", k, an, an_exp[k]); end
            checks++; if (seg !== seg_exp[k]) begin errors++; $display("FAIL disp_seg%0d: got %h want %h", k, seg, seg_exp[k]); end
            if (k >= 2) begin
                checks++; if (dwell !== DWELL) begin errors++; $display("FAIL disp_dwell%0d: got %0d want %0d", k - 1, dwell, DWELL); end
            end
        end
        ena2 = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL disp_off_an: got %b want 1111", an); end
        checks++; if (seg !== 8'hFF) begin errors++; $display("FAIL disp_off_seg: got %h want ff", seg); end
    endtask

    task automatic test_no_slave();
        bit ok_s, ok_p;
        int lat, n0;
        slave_present = 1'b0;
        rd_val        = 8'h77;
        n0            = byte_q.size();
        do_txn(SLV_ADDR, 1'b1, ok_s, ok_p, lat);
        checks++; if (!ok_s || !ok_p) begin errors++; $display("FAIL nack_start_stop: got start=%b stop=%b want 1 1", ok_s, ok_p); end
        checks++; if (byte_q[n0] !== 8'h91) begin errors++; $display("FAIL nack_addr_byte: got %h want 91", byte_q[n0]); end
        checks++; if (rise_cnt !== 10) begin errors++; $display("FAIL nack_scl_pulses: got %0d want 10", rise_cnt); end
        checks++; if (data_rd !== 8'h19) begin errors++; $display("FAIL nack_data_rd: got %h want 19", data_rd); end
    endtask

    task automatic test_write();
        bit ok_s, ok_p;
        int lat, n0;
        slave_present = 1'b1;
        rd_val        = 8'h55;
        n0            = byte_q.size();
        do_txn(SLV_ADDR, 1'b0, ok_s, ok_p, lat);
        checks++; if (!ok_s || !ok_p) begin errors++; $display("FAIL write_start_stop: got start=%b stop=%b want 1 1", ok_s, ok_p); end
        checks++; if (byte_q.size() !== n0 + 2) begin errors++; $display("FAIL write_nbytes: got %0d want 2", byte_q.size() - n0); end
        checks++; if (byte_q[n0] !== 8'h90) begin errors++; $display("FAIL write_addr_byte: got %h want 90", byte_q[n0]); end
        checks++; if (byte_q[n0 + 1] !== 8'h00) begin errors++; $display("FAIL write_ptr_byte: got %h want 00", byte_q[n0 + 1]); end
        checks++; if (rise_cnt !== 19) begin errors++; $display("FAIL write_scl_pulses: got %0d want 19", rise_cnt); end
        checks++; if (data_rd !== 8'h19) begin errors++; $display("FAIL write_data_rd: got %h want 19", data_rd); end
    endtask

    task automatic test_reset_mid_read();
        bit reached, ok;
        int s0, p0;
        slave_present = 1'b1;
        rd_val        = 8'hA5;
        addr_i        = SLV_ADDR;
        rw_i          = 1'b1;
        s0            = start_cnt;
        ena           = 1'b1;
        for (int i = 0; i < QTR * 4; i++) begin
            @(negedge clk);
            if (start_cnt > s0) break;
        end
        ena     = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < QTR * 4 * 20; i++) begin
            @(negedge clk);
            if (mode == M_RDATA && bit_n == 3) begin reached = 1'b1; break; end
        end
        checks++; if (!reached) begin errors++; $display("FAIL midrd_reach_rd: got mode=%0d want RDATA", mode); end
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if (scl !== 1'b1) begin errors++; $display("FAIL midrd_scl_release: got %b want 1", scl); end
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL midrd_sda_release: got %b want 1", sda); end
        checks++; if (data_rd !== 8'h00) begin errors++; $display("FAIL midrd_data_rd: got %h want 00", data_rd); end
        ena = 1'b1;
        repeat (3) @(negedge clk);
        s0 = start_cnt;
        p0 = stop_cnt;
        reset_n = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < QTR * 4; i++) begin
            @(negedge clk);
            if (start_cnt > s0) begin ok = 1'b1; break; end
        end
        ena = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL midrd_restart: got none want START"); end
        ok = 1'b0;
        for (int i = 0; i < QTR * 4 * 30; i++) begin
            @(negedge clk);
            if (stop_cnt > p0) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL midrd_restart_stop: got none want STOP"); end
        checks++; if (data_rd !== 8'hA5) begin errors++; $display("FAIL midrd_new_data: got %h want a5", data_rd); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_read();
        test_display();
        test_no_slave();
        test_write();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit hit, want normal finish");
        $fatal(1, "watchdog");
    end

endmodule
